// File: rtl/exe_stage_pkg.sv
// Shared widths, bus layouts, opcode bit indices and divider states for the execute stage.
package exe_stage_pkg;

  localparam int DS_TO_ES_BUS_WD = 160;
  localparam int ES_TO_MS_BUS_WD = 79;
  localparam int ES_FWD_BUS_WD   = 39;

  localparam int DIV_W  = 0;
  localparam int MOD_W  = 1;
  localparam int DIV_WU = 2;
  localparam int MOD_WU = 3;

  localparam int ST_H  = 0;
  localparam int ST_B  = 1;
  localparam int ST_W  = 2;
  localparam int LD_HU = 3;
  localparam int LD_H  = 4;
  localparam int LD_BU = 5;
  localparam int LD_B  = 6;
  localparam int LD_W  = 7;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  typedef struct packed {
    logic [3:0]  div_op;
    logic [7:0]  mem_op;
    logic        res_from_mem;
    logic        gr_we;
    logic        mem_we;
    logic [4:0]  dest;
    logic [11:0] alu_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] rkd;
    logic [31:0] pc;
  } ds_bus_t;

  typedef struct packed {
    logic [7:0]  mem_op;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_ms_bus_t;

  typedef struct packed {
    logic        fwd_valid;
    logic        fwd_is_load;
    logic [4:0]  dest;
    logic [31:0] result;
  } es_fwd_t;

  // Misaligned low address bits are simply ignored, never trapped.
  function automatic logic [3:0] st_byte_en(input logic [7:0] mem_op, input logic [1:0] addr_lo);
    logic [3:0] be;
    be = 4'h0;
    if (mem_op[ST_W])      be = 4'hF;
    else if (mem_op[ST_H]) be = addr_lo[1] ? 4'b1100 : 4'b0011;
    else if (mem_op[ST_B]) be = 4'b0001 << addr_lo;
    return be;
  endfunction

endpackage

// File: rtl/exe_stage_alu.sv
// Single-cycle combinational ALU driven by a one-hot alu_op; no state, no backpressure.
module exe_stage_alu
  import exe_stage_pkg::*;
(
  input  logic [11:0] i_alu_op,
  input  logic [31:0] i_src1,
  input  logic [31:0] i_src2,
  output logic [31:0] o_result
);

  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic [31:0] w_slt;
  logic [31:0] w_sltu;
  logic [31:0] w_sra;

  assign w_sum  = i_src1 + i_src2;
  assign w_diff = i_src1 - i_src2;
  assign w_slt  = {31'd0, $signed(i_src1) < $signed(i_src2)};
  assign w_sltu = {31'd0, i_src1 < i_src2};
  assign w_sra  = $unsigned($signed(i_src1) >>> i_src2[4:0]);

  assign o_result = ({32{i_alu_op[ALU_ADD]}}  & w_sum)
                  | ({32{i_alu_op[ALU_SUB]}}  & w_diff)
                  | ({32{i_alu_op[ALU_SLT]}}  & w_slt)
                  | ({32{i_alu_op[ALU_SLTU]}} & w_sltu)
                  | ({32{i_alu_op[ALU_AND]}}  & (i_src1 & i_src2))
                  | ({32{i_alu_op[ALU_NOR]}}  & ~(i_src1 | i_src2))
                  | ({32{i_alu_op[ALU_OR]}}   & (i_src1 | i_src2))
                  | ({32{i_alu_op[ALU_XOR]}}  & (i_src1 ^ i_src2))
                  | ({32{i_alu_op[ALU_SLL]}}  & (i_src1 << i_src2[4:0]))
                  | ({32{i_alu_op[ALU_SRL]}}  & (i_src1 >> i_src2[4:0]))
                  | ({32{i_alu_op[ALU_SRA]}}  & w_sra)
                  | ({32{i_alu_op[ALU_LUI]}}  & i_src2);

endmodule

// File: rtl/exe_stage_div_iter.sv
// Iterative restoring divider: 32 BUSY steps after start, then DONE holds q/r until i_ack.
module exe_stage_div_iter
  import exe_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_signed,
  input  logic        i_ack,
  input  logic [31:0] i_x,
  input  logic [31:0] i_y,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_q,
  output logic [31:0] o_r
);

  div_state_t  r_state;
  div_state_t  w_next;
  logic [4:0]  r_count;
  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_divisor;
  logic [31:0] r_x;
  logic        r_q_neg;
  logic        r_r_neg;
  logic        r_div0;
  logic [32:0] w_shift;
  logic [32:0] w_trial;

  always_ff @(posedge clk) begin
    if (reset) r_state <= DIV_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      DIV_IDLE: if (i_start) w_next = DIV_BUSY;
      DIV_BUSY: if (r_count == 5'd31) w_next = DIV_DONE;
      DIV_DONE: if (i_ack) w_next = DIV_IDLE;
      default:  w_next = DIV_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state == DIV_BUSY);
    o_done = (r_state == DIV_DONE);
  end

  // Bit 32 of the trial difference is set exactly when the divisor does not fit.
  assign w_shift = {r_rem, r_quo[31]};
  assign w_trial = w_shift - {1'b0, r_divisor};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= 5'd0;
      r_quo     <= 32'd0;
      r_rem     <= 32'd0;
      r_divisor <= 32'd0;
      r_x       <= 32'd0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_div0    <= 1'b0;
    end else if (r_state == DIV_IDLE && i_start) begin
      r_count   <= 5'd0;
      r_quo     <= (i_signed && i_x[31]) ? -i_x : i_x;
      r_rem     <= 32'd0;
      r_divisor <= (i_signed && i_y[31]) ? -i_y : i_y;
      r_x       <= i_x;
      r_q_neg   <= i_signed && (i_x[31] ^ i_y[31]);
      r_r_neg   <= i_signed && i_x[31];
      r_div0    <= (i_y == 32'd0);
    end else if (r_state == DIV_BUSY) begin
      r_count <= r_count + 5'd1;
      r_quo   <= {r_quo[30:0], ~w_trial[32]};
      r_rem   <= w_trial[32] ? w_shift[31:0] : w_trial[31:0];
    end
  end

  assign o_q = r_div0 ? 32'hFFFF_FFFF : (r_q_neg ? -r_quo : r_quo);
  assign o_r = r_div0 ? r_x           : (r_r_neg ? -r_rem : r_rem);

endmodule

// File: rtl/exe_stage.sv
// LoongArch32 EX stage: 1-cycle ALU ops, 33-cycle divides; holds its instruction while
// !ms_allowin or the divider is busy, and issues one SRAM request in the leaving cycle.
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic [ES_FWD_BUS_WD-1:0]   es_to_ds_fwd,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_we,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
);

  ds_bus_t     r_bus;
  logic        r_es_valid;
  logic [31:0] w_alu_result;
  logic [31:0] w_div_q;
  logic [31:0] w_div_r;
  logic [31:0] w_result;
  logic        w_is_div;
  logic        w_div_signed;
  logic        w_div_start;
  logic        w_div_busy;
  logic        w_div_done;
  logic        w_ready_go;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_req;
  es_ms_bus_t  w_ms_bus;
  es_fwd_t     w_fwd;

  assign w_is_div     = |r_bus.div_op;
  assign w_div_signed = r_bus.div_op[DIV_W] | r_bus.div_op[MOD_W];
  assign w_ready_go   = !w_is_div || w_div_done;

  assign es_allowin     = !r_es_valid || (w_ready_go && ms_allowin);
  assign es_to_ms_valid = r_es_valid && w_ready_go;

  always_ff @(posedge clk) begin
    if (reset)           r_es_valid <= 1'b0;
    else if (es_allowin) r_es_valid <= ds_to_es_valid;
  end

  always_ff @(posedge clk) begin
    if (reset)                             r_bus <= '0;
    else if (ds_to_es_valid && es_allowin) r_bus <= ds_bus_t'(ds_to_es_bus);
  end

  exe_stage_alu u_alu (
    .i_alu_op (r_bus.alu_op),
    .i_src1   (r_bus.src1),
    .i_src2   (r_bus.src2),
    .o_result (w_alu_result)
  );

  // Start only from IDLE so a finished divide waiting on MEM is not relaunched.
  assign w_div_start = r_es_valid && w_is_div && !w_div_busy && !w_div_done;

  exe_stage_div_iter u_div (
    .clk      (clk),
    .reset    (reset),
    .i_start  (w_div_start),
    .i_signed (w_div_signed),
    .i_ack    (ms_allowin),
    .i_x      (r_bus.src1),
    .i_y      (r_bus.src2),
    .o_busy   (w_div_busy),
    .o_done   (w_div_done),
    .o_q      (w_div_q),
    .o_r      (w_div_r)
  );

  always_comb begin
    w_result = w_alu_result;
    if (r_bus.div_op[DIV_W] || r_bus.div_op[DIV_WU])      w_result = w_div_q;
    else if (r_bus.div_op[MOD_W] || r_bus.div_op[MOD_WU]) w_result = w_div_r;
  end

  assign w_is_load  = r_bus.mem_op[LD_W] | r_bus.mem_op[LD_B] | r_bus.mem_op[LD_BU]
                    | r_bus.mem_op[LD_H] | r_bus.mem_op[LD_HU];
  assign w_is_store = r_bus.mem_we;
  assign w_req      = es_to_ms_valid && ms_allowin && (w_is_load || w_is_store);

  assign data_sram_en   = w_req;
  assign data_sram_addr = w_alu_result;
  assign data_sram_we   = w_req ? st_byte_en(r_bus.mem_op, w_alu_result[1:0]) : 4'h0;

  always_comb begin
    data_sram_wdata = r_bus.rkd;
    if (r_bus.mem_op[ST_B])      data_sram_wdata = {4{r_bus.rkd[7:0]}};
    else if (r_bus.mem_op[ST_H]) data_sram_wdata = {2{r_bus.rkd[15:0]}};
  end

  always_comb begin
    w_ms_bus.mem_op       = r_bus.mem_op;
    w_ms_bus.res_from_mem = r_bus.res_from_mem;
    w_ms_bus.gr_we        = r_bus.gr_we;
    w_ms_bus.dest         = r_bus.dest;
    w_ms_bus.alu_result   = w_result;
    w_ms_bus.pc           = r_bus.pc;
  end
  assign es_to_ms_bus = w_ms_bus;

  // A divide still in flight looks like a load to ID so it stalls on a match.
  always_comb begin
    w_fwd.fwd_valid   = r_es_valid && r_bus.gr_we && (r_bus.dest != 5'd0);
    w_fwd.fwd_is_load = r_bus.res_from_mem || (w_is_div && !w_ready_go);
    w_fwd.dest        = r_bus.dest;
    w_fwd.result      = w_result;
  end
  assign es_to_ds_fwd = w_fwd;

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed cases with literal expectations plus random traffic
// compared every cycle against an instruction-level model of the stage.
module tb_exe_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         ms_allowin;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [159:0] ds_to_es_bus;
  logic         es_to_ms_valid;
  logic [78:0]  es_to_ms_bus;
  logic [38:0]  es_to_ds_fwd;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  always #5 clk = ~clk;

  exe_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ms_allowin      (ms_allowin),
    .es_allowin      (es_allowin),
    .ds_to_es_valid  (ds_to_es_valid),
    .ds_to_es_bus    (ds_to_es_bus),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .es_to_ds_fwd    (es_to_ds_fwd),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction layout: {div_op,mem_op,rfm,gr_we,mem_we,dest,alu_op,src1,src2,rkd,pc}
  function automatic logic [159:0] mk(input logic [3:0] dop, input logic [7:0] mop,
                                      input logic rfm, input logic gwe, input logic mwe,
                                      input logic [4:0] dest, input logic [11:0] aop,
                                      input logic [31:0] s1, input logic [31:0] s2,
                                      input logic [31:0] rkd, input logic [31:0] pc);
    return {dop, mop, rfm, gwe, mwe, dest, aop, s1, s2, rkd, pc};
  endfunction

  function automatic logic [31:0] ref_alu(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[0])  return a + b;
    if (op[1])  return a - b;
    if (op[2])  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    if (op[3])  return (a < b) ? 32'd1 : 32'd0;
    if (op[4])  return a & b;
    if (op[5])  return ~(a | b);
    if (op[6])  return a | b;
    if (op[7])  return a ^ b;
    if (op[8])  return a << b[4:0];
    if (op[9])  return a >> b[4:0];
    if (op[10]) return $signed(a) >>> b[4:0];
    if (op[11]) return b;
    return 32'd0;
  endfunction

  function automatic logic [31:0] ref_div(input logic [3:0] dop, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (dop[0] || dop[1]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000; r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b; r = a % b;
    end
    return (dop[0] || dop[2]) ? q : r;
  endfunction

  function automatic logic [31:0] exp_result(input logic [159:0] ins);
    if (ins[159:156] != 4'd0) return ref_div(ins[159:156], ins[127:96], ins[95:64]);
    return ref_alu(ins[139:128], ins[127:96], ins[95:64]);
  endfunction

  // Model: which instruction sits in EX and how many cycles it has been there.
  bit           chk_en = 1'b0;
  bit           m_valid = 1'b0;
  logic [159:0] m_ins = '0;
  int           m_age = 0;

  always @(posedge clk) begin : model
    bit rdy, alw;
    rdy = m_valid && (m_ins[159:156] == 4'd0 || m_age >= 33);
    alw = !m_valid || (rdy && ms_allowin);
    if (reset) begin
      m_valid = 1'b0;
      m_age   = 0;
    end else if (alw) begin
      m_valid = ds_to_es_valid;
      if (ds_to_es_valid) begin
        m_ins = ds_to_es_bus;
        m_age = 0;
      end
    end else begin
      m_age++;
    end
  end

  always @(negedge clk) begin : compare
    logic [159:0] ins;
    bit div, rdy, fv, en, ld;
    logic [31:0] res, addr;
    logic [3:0]  we;
    logic [31:0] wd;
    if (chk_en) begin
      #1;
      ins  = m_ins;
      div  = ins[159:156] != 4'd0;
      rdy  = m_valid && (!div || m_age >= 33);
      res  = exp_result(ins);
      addr = ins[127:96] + ins[95:64];
      ld   = ins[155:151] != 5'd0;
      check("es_allowin", es_allowin, !m_valid || (rdy && ms_allowin));
      check("es_to_ms_valid", es_to_ms_valid, rdy);
      if (rdy) begin
        check("ms_bus_ctl", es_to_ms_bus[78:64], {ins[155:146], ins[144:140]});
        check("ms_bus_result", es_to_ms_bus[63:32], res);
        check("ms_bus_pc", es_to_ms_bus[31:0], ins[31:0]);
      end
      fv = m_valid && ins[146] && ins[144:140] != 5'd0;
      check("fwd_valid", es_to_ds_fwd[38], fv);
      if (fv) begin
        check("fwd_is_load", es_to_ds_fwd[37], ins[147] || (div && !rdy));
        check("fwd_dest", es_to_ds_fwd[36:32], ins[144:140]);
        if (!(div && !rdy)) check("fwd_result", es_to_ds_fwd[31:0], res);
      end
      en = rdy && ms_allowin && (ins[145] || ld);
      check("sram_en", data_sram_en, en);
      if (en) begin
        we = 4'h0;
        wd = ins[63:32];
        if (ins[150])      we = 4'hF;
        else if (ins[148]) we = addr[1] ? 4'b1100 : 4'b0011;
        else if (ins[149]) we = 4'(1 << addr[1:0]);
        if (ins[149])      wd = {4{ins[39:32]}};
        else if (ins[148]) wd = {2{ins[47:32]}};
        check("sram_addr", data_sram_addr, addr);
        check("sram_we", data_sram_we, we);
        if (ins[145]) check("sram_wdata", data_sram_wdata, wd);
      end
    end
  end

  task automatic drive(input bit v, input logic [159:0] b, input bit msa, input bit rst);
    @(negedge clk);
    ds_to_es_valid = v;
    ds_to_es_bus   = b;
    ms_allowin     = msa;
    reset          = rst;
  endtask

  task automatic run_div(input string name, input logic [3:0] dop, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    int  k;
    bit  stalled_ok;
    k = 0;
    stalled_ok = 1'b1;
    drive(1'b1, mk(dop, 8'd0, 1'b0, 1'b1, 1'b0, 5'd9, 12'h001, a, b, 32'd0, 32'h1c00_0100), 1'b1, 1'b0);
    while (k < 40) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      #1;
      if (es_to_ms_valid) break;
      if (es_allowin) stalled_ok = 1'b0;
      k++;
    end
    check({name, "_latency"}, k, 33);
    check({name, "_allowin_low"}, stalled_ok, 1'b1);
    check({name, "_result"}, es_to_ms_bus[63:32], exp);
  endtask

  function automatic logic [31:0] rv();
    case ($urandom % 8)
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [159:0] gen();
    logic [3:0]  dop;
    logic [7:0]  mop;
    logic        rfm, gwe, mwe;
    logic [11:0] aop;
    int          kind;
    dop = 4'd0; mop = 8'd0; rfm = 1'b0; gwe = 1'b1; mwe = 1'b0;
    aop = 12'(1) << ($urandom % 12);
    kind = $urandom % 8;
    case (kind)
      3: begin mop = 8'(1) << (3 + $urandom % 5); rfm = 1'b1; aop = 12'h001; end
      4: begin mop = 8'(1) << ($urandom % 3); mwe = 1'b1; gwe = 1'b0; aop = 12'h001; end
      5: dop = 4'(1) << ($urandom % 4);
      default: ;
    endcase
    return mk(dop, mop, rfm, gwe, mwe, 5'($urandom), aop, rv(), rv(), $urandom, $urandom);
  endfunction

  initial begin
    logic [159:0] stw;
    reset = 1'b1; ds_to_es_valid = 1'b0; ds_to_es_bus = '0; ms_allowin = 1'b1;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    check("rst_es_to_ms_valid", es_to_ms_valid, 1'b0);
    check("rst_sram_en", data_sram_en, 1'b0);
    check("rst_sram_we", data_sram_we, 4'h0);
    check("rst_fwd_valid", es_to_ds_fwd[38], 1'b0);
    check("rst_es_allowin", es_allowin, 1'b1);

    // add.w 5+7
    drive(1'b1, mk(4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 5'd4, 12'h001, 32'd5, 32'd7, 32'd0, 32'h1c00_0000), 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    check("add_valid", es_to_ms_valid, 1'b1);
    check("add_result", es_to_ms_bus[63:32], 32'd12);
    check("add_sram_en", data_sram_en, 1'b0);

    // st.b rkd=0x12345678 at 0x1003
    drive(1'b1, mk(4'd0, 8'b0000_0010, 1'b0, 1'b0, 1'b1, 5'd0, 12'h001, 32'h1000, 32'd3, 32'h1234_5678, 32'h1c00_0004), 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    check("stb_en", data_sram_en, 1'b1);
    check("stb_we", data_sram_we, 4'b1000);
    check("stb_wdata", data_sram_wdata, 32'h7878_7878);
    check("stb_addr", data_sram_addr, 32'h1003);
    drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    check("stb_en_once", data_sram_en, 1'b0);

    run_div("divw", 4'b0001, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_div("modw", 4'b0010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_div("divwu0", 4'b0100, 32'd100, 32'd0, 32'hFFFF_FFFF);
    run_div("modwu0", 4'b1000, 32'd100, 32'd0, 32'd100);
    run_div("divw_ovf", 4'b0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);

    // st.w held by MEM backpressure
    drive(1'b0, '0, 1'b1, 1'b0);
    stw = mk(4'd0, 8'b0000_0100, 1'b0, 1'b0, 1'b1, 5'd0, 12'h001, 32'h2000, 32'd0, 32'hCAFE_F00D, 32'h1c00_0008);
    drive(1'b1, stw, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      drive(1'b0, '0, 1'b0, 1'b0);
      #1;
      check("stw_hold_en", data_sram_en, 1'b0);
      check("stw_hold_valid", es_to_ms_valid, 1'b1);
      check("stw_hold_addr", data_sram_addr, 32'h2000);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    check("stw_en", data_sram_en, 1'b1);
    check("stw_we", data_sram_we, 4'hF);
    check("stw_wdata", data_sram_wdata, 32'hCAFE_F00D);
    drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    check("stw_en_once", data_sram_en, 1'b0);

    // Reset in the middle of a divide (BUSY count=10)
    drive(1'b1, mk(4'b0001, 8'd0, 1'b0, 1'b1, 1'b0, 5'd3, 12'h001, 32'd1000, 32'd7, 32'd0, 32'h1c00_000c), 1'b1, 1'b0);
    repeat (11) drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    check("rst_mid_valid", es_to_ms_valid, 1'b0);
    check("rst_mid_allowin", es_allowin, 1'b1);
    check("rst_mid_fwd", es_to_ds_fwd[38], 1'b0);
    check("rst_mid_en", data_sram_en, 1'b0);
    run_div("div_after_rst", 4'b0001, 32'd1000, 32'd7, 32'd142);

    for (int c = 0; c < 4000; c++) begin
      drive(($urandom % 10) < 7, gen(), ($urandom % 4) != 0, ($urandom % 500) == 0);
    end
    repeat (40) drive(1'b0, '0, 1'b1, 1'b0);
    #2;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
